// File: rtl/gomoku_pkg.sv
// Shared gomoku definitions: cell encoding, scan directions and board geometry.
// GameFsm, win_scanner and VgaPixelGen all import this package so that board
// indices and cell codes mean the same thing everywhere.
package gomoku_pkg;

  localparam int N       = 6;              // board side length
  localparam int CELLS   = N * N;          // index = row*N + col
  localparam int WIN_LEN = 5;              // stones in a row required to win
  localparam int IDX_W   = $clog2(CELLS);  // width of a cell index

  // Code 3 is unused; anything other than P1/P2 behaves as EMPTY.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    P1    = 2'd1,
    P2    = 2'd2
  } cell_t;

  // Step taken from the anchor cell for each successive stone of a line.
  typedef enum logic [1:0] {
    DIR_E  = 2'd0,  // col+1
    DIR_S  = 2'd1,  // row+1
    DIR_SE = 2'd2,  // row+1, col+1
    DIR_SW = 2'd3   // row+1, col-1
  } dir_t;

endpackage

// File: rtl/line_checker.sv
// Combinational evaluation of one candidate line.
// Ports:
//   snap      - board snapshot, one cell_t per cell
//   anchor    - index of the first cell of the line
//   dir       - direction the line extends from the anchor
//   in_bounds - all WIN_LEN cells of the line lie on the board
//   owner     - P1/P2 when every cell of the line holds that player, else EMPTY
module line_checker
  import gomoku_pkg::*;
(
  input  cell_t            snap [CELLS-1:0],
  input  logic [IDX_W-1:0] anchor,
  input  dir_t             dir,
  output logic             in_bounds,
  output cell_t            owner
);

  int               row;
  int               col;
  int               dr;
  int               dc;
  int               r;
  int               c;
  logic             all_p1;
  logic             all_p2;
  logic [IDX_W-1:0] idx;

  // NOTE: every variable gets a default at the top of the block, so no path
  // through the case/loop leaves one unassigned and no latch is inferred.
  always_comb begin
    row       = int'(anchor) / N;
    col       = int'(anchor) % N;
    dr        = 0;
    dc        = 1;
    in_bounds = 1'b0;
    r         = 0;
    c         = 0;
    idx       = '0;

    case (dir)
      DIR_E: begin
        dr        = 0;
        dc        = 1;
        in_bounds = (col + WIN_LEN - 1 < N);
      end
      DIR_S: begin
        dr        = 1;
        dc        = 0;
        in_bounds = (row + WIN_LEN - 1 < N);
      end
      DIR_SE: begin
        dr        = 1;
        dc        = 1;
        in_bounds = (row + WIN_LEN - 1 < N) && (col + WIN_LEN - 1 < N);
      end
      DIR_SW: begin
        dr        = 1;
        dc        = -1;
        in_bounds = (row + WIN_LEN - 1 < N) && (col >= WIN_LEN - 1);
      end
      default: ;
    endcase

    // An out-of-bounds line can never hit; the cell reads are skipped so
    // no off-board index is ever formed.
    all_p1 = in_bounds;
    all_p2 = in_bounds;
    if (in_bounds) begin
      for (int i = 0; i < WIN_LEN; i++) begin
        r   = row + i * dr;
        c   = col + i * dc;
        idx = IDX_W'(r * N + c);
        if (snap[idx] != P1) all_p1 = 1'b0;
        if (snap[idx] != P2) all_p2 = 1'b0;
      end
    end

    if (all_p1)      owner = P1;
    else if (all_p2) owner = P2;
    else             owner = EMPTY;
  end

endmodule

// File: rtl/win_scanner.sv
// Sequential five-in-a-row detector for the gomoku board.
// A start pulse snapshots the board, then one candidate line (anchor*4 + dir)
// is checked per cycle until the first winning line or the last candidate.
// Ports:
//   clk, rst  - clock; asynchronous active-high reset
//   board     - live board from GameFsm
//   start     - 1-cycle pulse, accepted only when idle
//   busy      - high during scan cycles
//   done      - 1-cycle pulse when results become valid
//   winner    - winning player, EMPTY if none
//   win_cell  - anchor index of the winning line
//   win_dir   - direction of the winning line
//   full      - snapshot holds no EMPTY cell
module win_scanner
  import gomoku_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  cell_t            board [CELLS-1:0],
  input  logic             start,
  output logic             busy,
  output logic             done,
  output cell_t            winner,
  output logic [IDX_W-1:0] win_cell,
  output dir_t             win_dir,
  output logic             full
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  cell_t            snap [CELLS-1:0];
  logic [IDX_W-1:0] anchor;
  dir_t             dir;
  logic             cand_in_bounds;
  cell_t            cand_owner;
  logic             hit;
  logic             last_cand;
  logic             board_full;
  logic             accept;

  line_checker u_line_checker (
    .snap      (snap),
    .anchor    (anchor),
    .dir       (dir),
    .in_bounds (cand_in_bounds),
    .owner     (cand_owner)
  );

  assign accept    = (state == IDLE) && start;
  assign hit       = cand_in_bounds && (cand_owner != EMPTY);
  assign last_cand = (anchor == IDX_W'(CELLS - 1)) && (dir == DIR_SW);
  assign busy      = (state == SCAN);
  assign done      = (state == DONE);

  // Full is judged on the same board value that is captured into snap.
  always_comb begin
    board_full = 1'b1;
    for (int i = 0; i < CELLS; i++) begin
      if (board[i] != P1 && board[i] != P2) board_full = 1'b0;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SCAN;
      SCAN:    if (hit || last_cand) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement or block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      anchor   <= '0;
      dir      <= DIR_E;
      winner   <= EMPTY;
      win_cell <= '0;
      win_dir  <= DIR_E;
      full     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            anchor   <= '0;
            dir      <= DIR_E;
            winner   <= EMPTY;
            win_cell <= '0;
            win_dir  <= DIR_E;
            full     <= board_full;
          end
        end
        SCAN: begin
          if (hit) begin
            winner   <= cand_owner;
            win_cell <= anchor;
            win_dir  <= dir;
          end else if (!last_cand) begin
            if (dir == DIR_SW) begin
              dir    <= DIR_E;
              anchor <= anchor + 1'b1;
            end else begin
              dir    <= dir_t'(dir + 2'd1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the snapshot is a plain storage array with no reset: it is always
  // loaded on an accepted start before any scan reads it.
  always_ff @(posedge clk) begin
    if (accept) snap <= board;
  end

endmodule

// File: tb/tb_win_scanner.sv
// Self-checking bench for win_scanner: directed boards plus randomized boards,
// each compared against a reference model that counts stones along every
// straight line on a 2-D view of the board.
module tb_win_scanner;
  import gomoku_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  cell_t            board [CELLS-1:0];
  logic             start;
  logic             busy;
  logic             done;
  cell_t            winner;
  logic [IDX_W-1:0] win_cell;
  dir_t             win_dir;
  logic             full;

  cell_t            cur [CELLS-1:0];
  int               n_pass  = 0;
  int               n_total = 0;
  int               done_at;
  int               seen;

  win_scanner dut (
    .clk      (clk),
    .rst      (rst),
    .board    (board),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .winner   (winner),
    .win_cell (win_cell),
    .win_dir  (win_dir),
    .full     (full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // First line in scan order (anchor ascending, then E,S,SE,SW) whose
  // WIN_LEN on-board stones all belong to one player.
  function automatic void model(input cell_t b [CELLS-1:0], output int k_hit,
                                output int who, output bit f);
    int dr [4];
    int dc [4];
    int r0, c0, r, c, n1, n2;
    dr = '{0, 1, 1, 1};
    dc = '{1, 0, 1, -1};
    k_hit = -1;
    who   = 0;
    f     = 1'b1;
    for (int i = 0; i < CELLS; i++)
      if (b[i] != P1 && b[i] != P2) f = 1'b0;
    for (int a = 0; a < CELLS && k_hit < 0; a++) begin
      for (int d = 0; d < 4 && k_hit < 0; d++) begin
        r0 = a / N;
        c0 = a % N;
        n1 = 0;
        n2 = 0;
        for (int i = 0; i < WIN_LEN; i++) begin
          r = r0 + i * dr[d];
          c = c0 + i * dc[d];
          if (r >= 0 && r < N && c >= 0 && c < N) begin
            if (b[r * N + c] == P1) n1++;
            if (b[r * N + c] == P2) n2++;
          end
        end
        if (n1 == WIN_LEN) begin k_hit = a * 4 + d; who = 1; end
        if (n2 == WIN_LEN) begin k_hit = a * 4 + d; who = 2; end
      end
    end
  endfunction

  // Starts a scan of cur in cycle 0 and checks every result against the model.
  // clear_cyc: cycle in which the live board is wiped; restart_cyc: cycle with
  // an extra start pulse (both -1 for none).
  task automatic run_scan(input string tag, input int clear_cyc, input int restart_cyc,
                          output int done_cyc);
    int k_hit, who, exp_done, busy_n, overlap;
    bit f;
    model(cur, k_hit, who, f);
    exp_done = (k_hit >= 0) ? k_hit + 2 : 4 * CELLS + 1;
    done_cyc = -1;
    busy_n   = 0;
    overlap  = 0;
    board    = cur;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    for (int cyc = 1; cyc <= 4 * CELLS + 10; cyc++) begin
      if (busy) busy_n++;
      if (busy && done) overlap++;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (cyc == clear_cyc)
        for (int i = 0; i < CELLS; i++) board[i] = EMPTY;
      start = (cyc == restart_cyc);
      tick();
    end
    start = 1'b0;
    check({tag, ".done_cycle"}, done_cyc, exp_done);
    check({tag, ".busy_cycles"}, busy_n, exp_done - 1);
    check({tag, ".overlap"}, overlap, 0);
    check({tag, ".winner"}, winner, who);
    check({tag, ".win_cell"}, win_cell, (k_hit >= 0) ? k_hit / 4 : 0);
    check({tag, ".win_dir"}, win_dir, (k_hit >= 0) ? k_hit % 4 : 0);
    check({tag, ".full"}, full, f);
    tick();
    check({tag, ".done_one_cycle"}, done, 0);
    check({tag, ".idle_busy"}, busy, 0);
    check({tag, ".winner_hold"}, winner, who);
  endtask

  task automatic clear_cur();
    for (int i = 0; i < CELLS; i++) cur[i] = EMPTY;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    clear_cur();
    board = cur;
    #12;
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.winner", winner, EMPTY);
    check("reset.win_cell", win_cell, 0);
    check("reset.win_dir", win_dir, DIR_E);
    check("reset.full", full, 0);
    tick();
    rst = 1'b0;
    tick();

    // Empty board: full scan, no winner.
    clear_cur();
    run_scan("empty", -1, -1, done_at);
    check("empty.spec_done", done_at, 145);

    // P1 on row 0, cols 0-4: first candidate hits.
    clear_cur();
    for (int i = 0; i < 5; i++) cur[i] = P1;
    run_scan("p1_row0", -1, -1, done_at);
    check("p1_row0.spec_done", done_at, 2);

    // P2 anti-diagonal from (0,5): k=23.
    clear_cur();
    for (int i = 0; i < 5; i++) cur[5 + 5 * i] = P2;
    run_scan("p2_sw", -1, -1, done_at);
    check("p2_sw.spec_done", done_at, 25);

    // P2 column 5 rows 1-5, live board wiped mid-scan.
    clear_cur();
    for (int i = 1; i < 6; i++) cur[i * N + 5] = P2;
    run_scan("p2_col5_snap", 3, -1, done_at);
    check("p2_col5_snap.spec_done", done_at, 47);

    // Full board, no five in a row; stray start during scan is ignored.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        cur[r * N + c] = (((r + c / 2) % 2) == 0) ? P1 : P2;
    run_scan("full_nowin", -1, 50, done_at);
    check("full_nowin.spec_done", done_at, 145);

    // Reset in the middle of a winning scan.
    clear_cur();
    for (int i = 1; i < 6; i++) cur[i * N + 5] = P2;
    board = cur;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    #1;
    check("midrst.busy", busy, 0);
    check("midrst.done", done, 0);
    check("midrst.winner", winner, EMPTY);
    check("midrst.win_cell", win_cell, 0);
    check("midrst.win_dir", win_dir, DIR_E);
    tick();
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 160; i++) begin
      if (done || busy) seen++;
      tick();
    end
    check("midrst.no_done", seen, 0);
    run_scan("after_rst", -1, -1, done_at);

    // Randomized boards biased toward one player so wins are common.
    for (int t = 0; t < 8; t++) begin
      int fav;
      fav = int'($urandom_range(1, 2));
      for (int i = 0; i < CELLS; i++) begin
        if ($urandom_range(0, 9) < 5)  cur[i] = cell_t'(fav);
        else if (t % 2 == 0)           cur[i] = cell_t'($urandom_range(1, 2));
        else                           cur[i] = cell_t'($urandom_range(0, 3));
      end
      run_scan($sformatf("rand%0d", t), -1, -1, done_at);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
